// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_dma
//  Description : Bus-initiator DMA engine. Copies LEN 32-bit words from SRC to
//                DST over the FemtoRV32 memory bus, programmed through a
//                4-register IO slave port, with a UART-style done interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_copy_dma #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_cs,
   input  logic                  cfg_wr,
   input  logic [1:0]            cfg_addr,
   input  logic [31:0]           cfg_wdata,
   output logic [31:0]           cfg_rdata,
   output logic                  bus_req,
   input  logic                  bus_grant,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [31:0]           m_wdata,
   output logic [3:0]            m_wmask,
   output logic                  m_rstrb,
   input  logic [31:0]           m_rdata,
   input  logic                  m_rbusy,
   input  logic                  m_wbusy,
   output logic                  irq,
   input  logic                  irq_acknowledge
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);
   localparam logic [LEN_WIDTH-1:0]  CNT_ONE   = LEN_WIDTH'(1);
   localparam logic [1:0]            REG_SRC   = 2'd0;
   localparam logic [1:0]            REG_DST   = 2'd1;
   localparam logic [1:0]            REG_LEN   = 2'd2;
   localparam logic [1:0]            REG_CTRL  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RD   = 3'd2,
      S_RDW  = 3'd3,
      S_WR   = 3'd4,
      S_WRW  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_reg_q, src_reg_d;
   logic [ADDR_WIDTH-1:0] dst_reg_q, dst_reg_d;
   logic [LEN_WIDTH-1:0]  len_reg_q, len_reg_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [31:0]           data_buf_q, data_buf_d;
   logic                  irq_en_q, irq_en_d;
   logic                  done_q, done_d;
   logic                  aborted_q, aborted_d;
   logic                  abort_pend_q, abort_pend_d;
   logic                  bus_req_q, bus_req_d;
   logic                  m_rstrb_q, m_rstrb_d;
   logic [3:0]            m_wmask_q, m_wmask_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [31:0]           m_wdata_q, m_wdata_d;
   logic                  irq_q, irq_d;

   logic                  cfg_we;
   logic                  busy;
   logic                  start_req;
   logic [LEN_WIDTH-1:0]  cnt_dec;

   assign cfg_we    = cfg_cs & cfg_wr;
   assign busy      = (state_q != S_IDLE);
   assign start_req = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[0] && !busy;
   // Counter saturates at zero so a stray decrement can never wrap it.
   assign cnt_dec   = (cnt_q != '0) ? (cnt_q - CNT_ONE) : '0;

   assign bus_req = bus_req_q;
   assign m_rstrb = m_rstrb_q;
   assign m_wmask = m_wmask_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign irq     = irq_q;

   // Next-state logic: register file updates, copy FSM and registered bus outputs.
   always_comb begin
      state_d      = state_q;
      src_reg_d    = src_reg_q;
      dst_reg_d    = dst_reg_q;
      len_reg_d    = len_reg_q;
      src_d        = src_q;
      dst_d        = dst_q;
      cnt_d        = cnt_q;
      data_buf_d   = data_buf_q;
      irq_en_d     = irq_en_q;
      done_d       = done_q;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q;

      // Address/length registers are frozen while a transfer is running.
      if (cfg_we && !busy) begin
         case (cfg_addr)
            REG_SRC: src_reg_d = {cfg_wdata[ADDR_WIDTH-1:2], 2'b00};
            REG_DST: dst_reg_d = {cfg_wdata[ADDR_WIDTH-1:2], 2'b00};
            REG_LEN: len_reg_d = cfg_wdata[LEN_WIDTH-1:0];
            default: ;
         endcase
      end

      if (cfg_we && (cfg_addr == REG_CTRL)) begin
         irq_en_d = cfg_wdata[2];
         // An abort only means something while a transfer is in flight.
         if (cfg_wdata[1] && busy) begin
            abort_pend_d = 1'b1;
         end
      end

      // Acknowledge first so that a completion in the same cycle wins.
      if (irq_acknowledge) begin
         done_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            abort_pend_d = 1'b0;
            if (start_req) begin
               if (len_reg_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  done_d    = 1'b0;
                  aborted_d = 1'b0;
                  src_d     = src_reg_q;
                  dst_d     = dst_reg_q;
                  cnt_d     = len_reg_q;
                  state_d   = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (bus_grant) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            state_d = S_RDW;
         end
         S_RDW: begin
            if (!m_rbusy) begin
               data_buf_d = m_rdata;
               state_d    = S_WR;
            end
         end
         S_WR: begin
            state_d = S_WRW;
         end
         S_WRW: begin
            if (!m_wbusy) begin
               src_d = src_q + ADDR_STEP;
               dst_d = dst_q + ADDR_STEP;
               cnt_d = cnt_dec;
               if (cnt_dec == '0) begin
                  done_d       = 1'b1;
                  abort_pend_d = 1'b0;
                  state_d      = S_DONE;
               end else if (abort_pend_q) begin
                  done_d       = 1'b1;
                  aborted_d    = 1'b1;
                  abort_pend_d = 1'b0;
                  state_d      = S_IDLE;
               end else if (bus_grant) begin
                  state_d = S_RD;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_DONE: begin
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bus outputs are a function of the state being entered, so they are
      // valid for exactly the cycles the FSM spends in that state.
      bus_req_d = (state_d == S_REQ) || (state_d == S_RD) || (state_d == S_RDW) ||
                  (state_d == S_WR)  || (state_d == S_WRW);
      m_rstrb_d = (state_d == S_RD);
      m_wmask_d = (state_d == S_WR) ? 4'hF : 4'h0;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      if (state_d == S_RD) begin
         m_addr_d = src_d;
      end else if (state_d == S_WR) begin
         m_addr_d  = dst_d;
         m_wdata_d = data_buf_d;
      end
      irq_d = done_d & irq_en_d;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         src_reg_q    <= '0;
         dst_reg_q    <= '0;
         len_reg_q    <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         cnt_q        <= '0;
         data_buf_q   <= '0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         bus_req_q    <= 1'b0;
         m_rstrb_q    <= 1'b0;
         m_wmask_q    <= 4'h0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_reg_q    <= src_reg_d;
         dst_reg_q    <= dst_reg_d;
         len_reg_q    <= len_reg_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         cnt_q        <= cnt_d;
         data_buf_q   <= data_buf_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         abort_pend_q <= abort_pend_d;
         bus_req_q    <= bus_req_d;
         m_rstrb_q    <= m_rstrb_d;
         m_wmask_q    <= m_wmask_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         irq_q        <= irq_d;
      end
   end

   // Slave read mux; STATUS carries the live remaining word count.
   always_comb begin
      cfg_rdata = 32'h0;
      case (cfg_addr)
         REG_SRC:  cfg_rdata = 32'(src_reg_q);
         REG_DST:  cfg_rdata = 32'(dst_reg_q);
         REG_LEN:  cfg_rdata = 32'(len_reg_q);
         default:  cfg_rdata = {16'(cnt_q), 12'h000, irq_en_q, aborted_q, done_q, busy};
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_dma
//  Description : Directed self-checking bench for mem_copy_dma with a small
//                memory responder that can stretch chosen reads and writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_copy_dma;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_cs, cfg_wr;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata, cfg_rdata;
   logic        bus_req, bus_grant;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wmask;
   logic        m_rstrb, m_rbusy, m_wbusy;
   logic        irq, irq_acknowledge;

   mem_copy_dma #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .cfg_cs          (cfg_cs),
      .cfg_wr          (cfg_wr),
      .cfg_addr        (cfg_addr),
      .cfg_wdata       (cfg_wdata),
      .cfg_rdata       (cfg_rdata),
      .bus_req         (bus_req),
      .bus_grant       (bus_grant),
      .m_addr          (m_addr),
      .m_wdata         (m_wdata),
      .m_wmask         (m_wmask),
      .m_rstrb         (m_rstrb),
      .m_rdata         (m_rdata),
      .m_rbusy         (m_rbusy),
      .m_wbusy         (m_wbusy),
      .irq             (irq),
      .irq_acknowledge (irq_acknowledge)
   );

   always #5 clk = ~clk;

   // Responder state (written only by the responder process).
   int          rd_num, wr_num, stab_err, rcnt, wcnt;
   logic [31:0] ra, wa, wd;
   bit   [31:0] wmem  [0:1023];
   bit          wflag [0:1023];
   // Responder stretch controls (written only by the stimulus process).
   int          rb_at, rb_len, wb_at, wb_len;

   function automatic logic [31:0] src_val(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'({22'd0, a[23], a[10:2]});
   endfunction

   // Memory responder: reads return src_val(addr); writes land in wmem.
   always @(posedge clk) begin
      if (!reset) begin
         m_rbusy <= 1'b0; m_wbusy <= 1'b0; m_rdata <= 32'h0;
         rcnt <= 0; wcnt <= 0; rd_num <= 0; wr_num <= 0; stab_err <= 0;
         ra <= 32'h0; wa <= 32'h0; wd <= 32'h0;
      end else begin
         if (m_rstrb) begin
            rd_num <= rd_num + 1;
            ra     <= m_addr;
            if (rb_len > 0 && rd_num == rb_at) begin
               m_rbusy <= 1'b1;
               rcnt    <= rb_len;
               m_rdata <= 32'hBAD0_BAD0;
            end else begin
               m_rdata <= src_val(m_addr);
            end
         end else if (rcnt != 0) begin
            if (m_addr != ra) stab_err <= stab_err + 1;
            if (rcnt == 1) begin
               m_rbusy <= 1'b0;
               m_rdata <= src_val(ra);
            end
            rcnt <= rcnt - 1;
         end
         if (m_wmask == 4'hF) begin
            wr_num             <= wr_num + 1;
            wmem[widx(m_addr)]  <= m_wdata;
            wflag[widx(m_addr)] <= 1'b1;
            wa <= m_addr;
            wd <= m_wdata;
            if (wb_len > 0 && wr_num == wb_at) begin
               m_wbusy <= 1'b1;
               wcnt    <= wb_len;
            end
         end else if (wcnt != 0) begin
            if (m_addr != wa || m_wdata != wd) stab_err <= stab_err + 1;
            if (wcnt == 1) m_wbusy <= 1'b0;
            wcnt <= wcnt - 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_cs = 1'b1; cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_cs = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd3; cfg_wdata = 32'h0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      cfg_addr = a;
      #1;
      v = cfg_rdata;
      cfg_addr = 2'd3;
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      irq_acknowledge = 1'b1;
      @(negedge clk);
      irq_acknowledge = 1'b0;
   endtask

   task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                        input logic [31:0] ctrl);
      cfg_write(2'd0, s);
      cfg_write(2'd1, d);
      cfg_write(2'd2, n);
      cfg_write(2'd3, ctrl);
   endtask

   int n_rd, n_wr, t_rd, t_done;
   bit timed_out;
   logic irq_at_done;

   // Watch a transfer until STATUS.done; optionally write abort in the
   // cycle after read number abort_at (its RDW cycle).
   task automatic run_xfer(input int budget, input int abort_at);
      int ab_phase;
      ab_phase = 0;
      n_rd = 0; n_wr = 0; t_rd = -1; t_done = -1; timed_out = 1'b1; irq_at_done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ab_phase == 2) begin
            cfg_cs = 1'b0; cfg_wr = 1'b0; cfg_wdata = 32'h0; ab_phase = 3;
         end
         if (ab_phase == 1) begin
            cfg_cs = 1'b1; cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'h2; ab_phase = 2;
         end
         if (m_rstrb) begin
            n_rd++;
            if (t_rd < 0) t_rd = i;
            if (abort_at > 0 && n_rd == abort_at) ab_phase = 1;
         end
         if (m_wmask != 4'h0) n_wr++;
         if (cfg_rdata[1]) begin
            t_done = i; timed_out = 1'b0; irq_at_done = irq;
            break;
         end
      end
      cfg_cs = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd3; cfg_wdata = 32'h0;
   endtask

   initial begin
      logic [31:0] v;
      int gap, gap_strobes, phase;
      logic saw_req;
      logic [31:0] a2;

      cfg_cs = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd3; cfg_wdata = 32'h0;
      bus_grant = 1'b1; irq_acknowledge = 1'b0;
      rb_at = -1; rb_len = 0; wb_at = -1; wb_len = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_eq("rst_ctl", {57'd0, bus_req, m_rstrb, m_wmask, irq}, 64'd0);
      chk_eq("rst_addr", m_addr, 64'd0);
      chk_eq("rst_wdata", m_wdata, 64'd0);
      chk_eq("rst_status", cfg_rdata, 64'd0);
      reset = 1'b1;

      // Basic 3-word copy, grant tied high, zero busy
      cfg_write(2'd0, 32'h0000_0103);
      read_reg(2'd0, v);
      chk_eq("src_align", v, 64'h100);
      setup(32'h100, 32'h0080_0000, 32'd3, 32'h1);
      run_xfer(200, 0);
      chk_eq("t1_timeout", timed_out, 64'd0);
      chk_eq("t1_nrd", n_rd, 64'd3);
      chk_eq("t1_nwr", n_wr, 64'd3);
      chk_eq("t1_cycles", t_done - t_rd, 64'd12);
      for (int k = 0; k < 3; k++)
         chk_eq("t1_word", wmem[widx(32'h0080_0000 + 32'(4 * k))], src_val(32'h100 + 32'(4 * k)));
      @(negedge clk);
      chk_eq("t1_status", cfg_rdata, 64'h2);

      // LEN==0 start: immediate done, no bus activity
      ack_pulse();
      chk_eq("ack_clear", cfg_rdata, 64'h0);
      cfg_write(2'd2, 32'd0);
      cfg_write(2'd3, 32'h1);
      chk_eq("len0_done", cfg_rdata, 64'h2);
      n_rd = 0; n_wr = 0;
      v = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_rstrb) n_rd++;
         if (m_wmask != 4'h0) n_wr++;
         v = v | {31'd0, cfg_rdata[0]};
      end
      chk_eq("len0_strobes", n_rd + n_wr, 64'd0);
      chk_eq("len0_busy", v, 64'd0);

      // Stretched read (5) and write (7) on the second word
      rb_at = rd_num + 1; rb_len = 5;
      wb_at = wr_num + 1; wb_len = 7;
      setup(32'h200, 32'h0080_0100, 32'd2, 32'h1);
      run_xfer(300, 0);
      chk_eq("t3_timeout", timed_out, 64'd0);
      chk_eq("t3_cycles", t_done - t_rd, 64'd20);
      chk_eq("t3_stable", stab_err, 64'd0);
      chk_eq("t3_w0", wmem[widx(32'h0080_0100)], src_val(32'h200));
      chk_eq("t3_w1", wmem[widx(32'h0080_0104)], src_val(32'h204));
      chk_eq("t3_nwr", n_wr, 64'd2);
      rb_len = 0; wb_len = 0;

      // Abort during word 2 RDW on a 4-word transfer
      setup(32'h300, 32'h0080_0200, 32'd4, 32'h1);
      run_xfer(300, 2);
      chk_eq("t4_timeout", timed_out, 64'd0);
      chk_eq("t4_nwr", n_wr, 64'd2);
      chk_eq("t4_w1", wmem[widx(32'h0080_0204)], src_val(32'h304));
      chk_eq("t4_w2_untouched", wflag[widx(32'h0080_0208)], 64'd0);
      @(negedge clk);
      chk_eq("t4_status", cfg_rdata, 64'h0002_0006);

      // Abort written while idle is discarded
      cfg_write(2'd3, 32'h2);
      setup(32'h300, 32'h0080_0300, 32'd2, 32'h1);
      run_xfer(200, 0);
      chk_eq("t4b_nwr", n_wr, 64'd2);
      @(negedge clk);
      chk_eq("t4b_status", cfg_rdata, 64'h2);

      // Grant revoked after word 1, restored later
      setup(32'h400, 32'h0080_0400, 32'd3, 32'h1);
      n_rd = 0; n_wr = 0; timed_out = 1'b1; phase = 0; gap = 0; gap_strobes = 0;
      saw_req = 1'b0; a2 = 32'h0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (phase == 1) begin
            gap++;
            if (m_rstrb || m_wmask != 4'h0) gap_strobes++;
            if (gap == 8) begin
               saw_req = bus_req; bus_grant = 1'b1; phase = 2;
            end
         end
         if (m_rstrb) begin
            n_rd++;
            if (n_rd == 2) a2 = m_addr;
         end
         if (m_wmask != 4'h0) begin
            n_wr++;
            if (n_wr == 1) begin
               bus_grant = 1'b0; phase = 1;
            end
         end
         if (cfg_rdata[1]) begin
            timed_out = 1'b0;
            break;
         end
      end
      bus_grant = 1'b1;
      chk_eq("t5_timeout", timed_out, 64'd0);
      chk_eq("t5_gap_strobes", gap_strobes, 64'd0);
      chk_eq("t5_req_held", saw_req, 64'd1);
      chk_eq("t5_resume_addr", a2, 64'h404);
      chk_eq("t5_w2", wmem[widx(32'h0080_0408)], src_val(32'h408));

      // Interrupt raise and acknowledge
      cfg_write(2'd3, 32'h4);
      ack_pulse();
      chk_eq("t6_irq_clr0", irq, 64'd0);
      setup(32'h500, 32'h0080_0500, 32'd1, 32'h5);
      run_xfer(200, 0);
      chk_eq("t6_irq_rise", irq_at_done, 64'd1);
      ack_pulse();
      chk_eq("t6_irq_ack", irq, 64'd0);
      chk_eq("t6_status", cfg_rdata, 64'h8);

      // Reset while stalled in RDW
      rb_at = rd_num; rb_len = 20;
      setup(32'h600, 32'h0080_0600, 32'd2, 32'h5);
      v = 32'h0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_rstrb) begin
            v = 32'h1;
            break;
         end
      end
      chk_eq("t7_reached_rd", v, 64'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      rb_len = 0;
      chk_eq("t7_ctl", {57'd0, bus_req, m_rstrb, m_wmask, irq}, 64'd0);
      chk_eq("t7_addr", m_addr, 64'd0);
      chk_eq("t7_wdata", m_wdata, 64'd0);
      chk_eq("t7_status", cfg_rdata, 64'd0);
      n_rd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_rstrb || m_wmask != 4'h0 || bus_req) n_rd++;
      end
      chk_eq("t7_quiet", n_rd, 64'd0);
      chk_eq("t7_no_write", wflag[widx(32'h0080_0600)], 64'd0);
      read_reg(2'd0, v);
      chk_eq("t7_src_reg", v, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
